// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder with fixed (high/low first) or round-robin
// arbitration, one-hot grant and a valid/ack result handshake.
module prio_encoder_rr #(
    parameter int N           = 8,
    parameter int W           = $clog2(N),
    parameter bit ROUND_ROBIN = 1'b0,
    parameter bit HIGH_FIRST  = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    input  logic         en,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] y,
    output logic [N-1:0] grant
);

    logic         valid_r;
    logic [W-1:0] y_r;
    logic [N-1:0] grant_r;
    logic [W-1:0] ptr_r;

    logic         any_s;
    logic         load_s;
    logic [W-1:0] win_s;
    logic [N-1:0] one_hot_s;

    // Highest set index; later (higher) hits overwrite earlier ones.
    function automatic logic [W-1:0] fixed_high(input logic [N-1:0] req);
        logic [W-1:0] win;
        win = '0;
        for (int i = 0; i < N; i++) begin
            win = req[i] ? W'(i) : win;
        end
        return win;
    endfunction

    function automatic logic [W-1:0] fixed_low(input logic [N-1:0] req);
        logic [W-1:0] win;
        win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            win = req[i] ? W'(i) : win;
        end
        return win;
    endfunction

    // Ascending search starting just after ptr; the wrap is mod N, so
    // non-power-of-2 N never yields an index >= N.
    function automatic logic [W-1:0] rr_pick(input logic [N-1:0] req,
                                             input logic [W-1:0] ptr);
        logic [W-1:0] win;
        logic [W:0]   sum;
        logic [W-1:0] idx;
        logic         found;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            sum   = {1'b0, ptr} + (W+1)'(k);
            sum   = (sum >= (W+1)'(N)) ? (sum - (W+1)'(N)) : sum;
            idx   = sum[W-1:0];
            win   = (req[idx] && !found) ? idx : win;
            found = found | req[idx];
        end
        return win;
    endfunction

    // Winner selection and load qualification.
    always_comb begin
        any_s  = |in;
        load_s = en && (!valid_r || ack);
        if (ROUND_ROBIN) begin
            win_s = rr_pick(in, ptr_r);
        end else if (HIGH_FIRST) begin
            win_s = fixed_high(in);
        end else begin
            win_s = fixed_low(in);
        end
        one_hot_s = {{(N-1){1'b0}}, 1'b1} << win_s;
    end

    // Result registers and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            y_r     <= '0;
            grant_r <= '0;
            ptr_r   <= W'(N - 1);
        end else if (load_s) begin
            if (any_s) begin
                valid_r <= 1'b1;
                y_r     <= win_s;
                grant_r <= one_hot_s;
                ptr_r   <= win_s;
            end else begin
                valid_r <= 1'b0;
                y_r     <= '0;
                grant_r <= '0;
            end
        end else if (ack && valid_r) begin
            // Consumed with no new sample: y keeps its last value.
            valid_r <= 1'b0;
            grant_r <= '0;
        end
    end

    assign valid = valid_r;
    assign y     = y_r;
    assign grant = grant_r;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Self-checking bench: four encoder configurations share one stimulus stream and are
// compared against a behavioural model, a vector table and hand-written sequences.
module tb_prio_encoder_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_v;
    logic       en;
    logic       ack;

    logic       hi_valid, lo_valid, rr_valid, r5_valid;
    logic [2:0] hi_y, lo_y, rr_y, r5_y;
    logic [7:0] hi_grant, lo_grant, rr_grant;
    logic [4:0] r5_grant;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    prio_encoder_rr #(.N(8), .ROUND_ROBIN(1'b0), .HIGH_FIRST(1'b1)) u_hi (
        .clk(clk), .rst_n(rst_n), .in(in_v), .en(en), .ack(ack),
        .valid(hi_valid), .y(hi_y), .grant(hi_grant));
    prio_encoder_rr #(.N(8), .ROUND_ROBIN(1'b0), .HIGH_FIRST(1'b0)) u_lo (
        .clk(clk), .rst_n(rst_n), .in(in_v), .en(en), .ack(ack),
        .valid(lo_valid), .y(lo_y), .grant(lo_grant));
    prio_encoder_rr #(.N(8), .ROUND_ROBIN(1'b1), .HIGH_FIRST(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in(in_v), .en(en), .ack(ack),
        .valid(rr_valid), .y(rr_y), .grant(rr_grant));
    prio_encoder_rr #(.N(5), .ROUND_ROBIN(1'b1), .HIGH_FIRST(1'b0)) u_r5 (
        .clk(clk), .rst_n(rst_n), .in(in_v[4:0]), .en(en), .ack(ack),
        .valid(r5_valid), .y(r5_y), .grant(r5_grant));

    // Reference model state, one slot per instance above.
    int              m_n  [4] = '{8, 8, 8, 5};
    int              m_rr [4] = '{0, 0, 1, 1};
    int              m_hf [4] = '{1, 0, 1, 0};
    logic            m_valid [4];
    int              m_y     [4];
    longint unsigned m_grant [4];
    int              m_ptr   [4];

    logic [63:0] act_valid [4];
    logic [63:0] act_y     [4];
    logic [63:0] act_grant [4];

    always_comb begin
        act_valid[0] = {63'd0, hi_valid};
        act_valid[1] = {63'd0, lo_valid};
        act_valid[2] = {63'd0, rr_valid};
        act_valid[3] = {63'd0, r5_valid};
        act_y[0]     = {61'd0, hi_y};
        act_y[1]     = {61'd0, lo_y};
        act_y[2]     = {61'd0, rr_y};
        act_y[3]     = {61'd0, r5_y};
        act_grant[0] = {56'd0, hi_grant};
        act_grant[1] = {56'd0, lo_grant};
        act_grant[2] = {56'd0, rr_grant};
        act_grant[3] = {59'd0, r5_grant};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 1'b0;
            m_y[k]     = 0;
            m_grant[k] = 64'd0;
            m_ptr[k]   = m_n[k] - 1;
        end
    endtask

    // Fixed: position of the highest (or isolated lowest) set bit via log2.
    // Round-robin: walk indices ptr+1, ptr+2, ... mod N.
    function automatic int ref_winner(input int k, input longint unsigned v);
        longint unsigned t;
        int              w;
        int              idx;
        if (m_rr[k] != 0) begin
            for (int s = 1; s <= m_n[k]; s++) begin
                idx = (m_ptr[k] + s) % m_n[k];
                if (v[idx]) return idx;
            end
            return -1;
        end
        t = (m_hf[k] != 0) ? v : (v & (~v + 64'd1));
        w = 0;
        while (t > 64'd1) begin
            t = t >> 1;
            w++;
        end
        return w;
    endfunction

    task automatic model_step();
        longint unsigned v;
        int              w;
        for (int k = 0; k < 4; k++) begin
            v = {56'd0, in_v} & ((64'd1 << m_n[k]) - 64'd1);
            if (en && (!m_valid[k] || ack)) begin
                if (v != 64'd0) begin
                    w          = ref_winner(k, v);
                    m_valid[k] = 1'b1;
                    m_y[k]     = w;
                    m_grant[k] = 64'd1 << w;
                    if (m_rr[k] != 0) m_ptr[k] = w;
                end else begin
                    m_valid[k] = 1'b0;
                    m_y[k]     = 0;
                    m_grant[k] = 64'd0;
                end
            end else if (ack && m_valid[k]) begin
                m_valid[k] = 1'b0;
                m_grant[k] = 64'd0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s.u%0d.valid", tag, k), act_valid[k], {63'd0, m_valid[k]});
            chk($sformatf("%s.u%0d.y", tag, k), act_y[k], 64'(m_y[k]));
            chk($sformatf("%s.u%0d.grant", tag, k), act_grant[k], m_grant[k]);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Called just after a rising edge: reset lands between edges and must act at once.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [7:0] v, input logic e, input logic a);
        in_v = v;
        en   = e;
        ack  = a;
    endtask

    typedef struct {
        logic [7:0] in_v;
        logic       en;
        logic       ack;
        logic       hv;
        logic [2:0] hy;
        logic [7:0] hg;
        logic       lv;
        logic [2:0] ly;
        logic [7:0] lg;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{8'h26, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 3'd1, 8'h02};
        vecs[1]  = '{8'h80, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 3'd1, 8'h02};
        vecs[2]  = '{8'h80, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 3'd1, 8'h02};
        vecs[3]  = '{8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 3'd1, 8'h02};
        vecs[4]  = '{8'h80, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 3'd1, 8'h02};
        vecs[5]  = '{8'h80, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1, 3'd7, 8'h80};
        vecs[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 3'd7, 8'h00};
        vecs[7]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        vecs[8]  = '{8'h01, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 3'd0, 8'h01};
        vecs[9]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 1'b1, 3'd0, 8'h01};
        vecs[10] = '{8'h03, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 3'd0, 8'h01};
        vecs[11] = '{8'h03, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02, 1'b1, 3'd0, 8'h01};
        vecs[12] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        vecs[13] = '{8'h26, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 3'd1, 8'h02};

        // Power-up reset, checked before any clock edge matters.
        rst_n = 1'b0;
        drive(8'h00, 1'b0, 1'b0);
        model_reset();
        #12;
        chk("reset.hi_valid", {63'd0, hi_valid}, 64'd0);
        chk("reset.hi_y", {61'd0, hi_y}, 64'd0);
        chk("reset.hi_grant", {56'd0, hi_grant}, 64'd0);
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed-priority vectors: load, hold rule, ack with/without en, zero input.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].in_v, vecs[i].en, vecs[i].ack);
            cycle("vec");
            chk($sformatf("vec%0d.hi_valid", i), {63'd0, hi_valid}, {63'd0, vecs[i].hv});
            chk($sformatf("vec%0d.hi_y", i), {61'd0, hi_y}, {61'd0, vecs[i].hy});
            chk($sformatf("vec%0d.hi_grant", i), {56'd0, hi_grant}, {56'd0, vecs[i].hg});
            chk($sformatf("vec%0d.lo_valid", i), {63'd0, lo_valid}, {63'd0, vecs[i].lv});
            chk($sformatf("vec%0d.lo_y", i), {61'd0, lo_y}, {61'd0, vecs[i].ly});
            chk($sformatf("vec%0d.lo_grant", i), {56'd0, lo_grant}, {56'd0, vecs[i].lg});
        end

        // Reset while a result is live must clear without a clock edge.
        chk("pre_rst.hi_valid", {63'd0, hi_valid}, 64'd1);
        async_reset();
        chk("mid_rst.hi_valid", {63'd0, hi_valid}, 64'd0);
        chk("mid_rst.hi_grant", {56'd0, hi_grant}, 64'd0);

        // Round-robin fairness with all requests held.
        drive(8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cycle("rr_fair");
            chk($sformatf("rr_fair%0d.y", i), {61'd0, rr_y}, 64'(i % 8));
            chk($sformatf("rr5_fair%0d.y", i), {61'd0, r5_y}, 64'(i % 5));
        end

        async_reset();
        drive(8'h81, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle("rr_edge");
            chk($sformatf("rr_edge%0d.y", i), {61'd0, rr_y}, (i % 2 == 0) ? 64'd0 : 64'd7);
        end

        // Sparse wrap: ptr lands on 6, then 0000_0110 gives 1 then 2.
        async_reset();
        drive(8'h40, 1'b1, 1'b1);
        cycle("rr_sparse");
        chk("rr_sparse.y6", {61'd0, rr_y}, 64'd6);
        drive(8'h06, 1'b1, 1'b1);
        cycle("rr_sparse");
        chk("rr_sparse.y1", {61'd0, rr_y}, 64'd1);
        cycle("rr_sparse");
        chk("rr_sparse.y2", {61'd0, rr_y}, 64'd2);

        // N=5 with requests at 0 and 4: wrap is mod 5.
        async_reset();
        drive(8'h11, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle("n5");
            chk($sformatf("n5_%0d.y", i), {61'd0, r5_y}, (i == 1) ? 64'd4 : 64'd0);
            chk($sformatf("n5_%0d.y_lt5", i), {63'd0, (r5_y < 3'd5)}, 64'd1);
        end

        // Randomised traffic against the model, with occasional mid-stream resets.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       in_v = 8'h00;
                1:       in_v = 8'(1 << $urandom_range(0, 7));
                2:       in_v = 8'($urandom) & 8'($urandom);
                default: in_v = 8'($urandom);
            endcase
            en  = ($urandom_range(0, 3) != 0);
            ack = ($urandom_range(0, 2) != 0);
            cycle("rand");
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
